// File: rtl/ones_vector_gen_pkg.sv
// ones_vector_pkg: shared constants, FSM state type and chunk helper for the
// ones_vector_gen block (builds a WIDTH-bit vector holding exactly N ones).
// Optional macro: ONES_VECTOR_GEN_ROTATE_EN (adds a rotate offset; see top).
package ones_vector_pkg;

  localparam int WIDTH  = 255;                          // output vector width
  localparam int CNT_W  = $clog2(WIDTH + 1);            // count width (8)
  localparam int CHUNK  = 16;                           // bits resolved per BUILD cycle
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;  // BUILD cycles per vector
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    DONE  = 2'd2
  } state_e;

  // First bit position of chunk idx; CNT_W+1 bits so positions up to WIDTH fit.
  function automatic logic [CNT_W:0] chunk_base(input logic [IDX_W-1:0] idx);
    return (CNT_W+1)'(int'(idx) * CHUNK);
  endfunction

endpackage

// File: rtl/ones_vector_gen_if.sv
// ones_vector_gen_if: request/response bundle of ones_vector_gen.
//   in_valid/in_ready/count[/offset] : request handshake (towards the block)
//   out_valid/out_ready/out          : completed vector handshake (from the block)
// slave modport = the generator, master modport = its driver.
// Optional macro: ONES_VECTOR_GEN_ROTATE_EN adds the offset signal.
interface ones_vector_gen_if;
  import ones_vector_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] count;
`ifdef ONES_VECTOR_GEN_ROTATE_EN
  logic [CNT_W-1:0] offset;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;

`ifdef ONES_VECTOR_GEN_ROTATE_EN
  modport slave  (input  in_valid, count, offset, out_ready,
                  output in_ready, out_valid, out);
  modport master (output in_valid, count, offset, out_ready,
                  input  in_ready, out_valid, out);
`else
  modport slave  (input  in_valid, count, out_ready,
                  output in_ready, out_valid, out);
  modport master (output in_valid, count, out_ready,
                  input  in_ready, out_valid, out);
`endif

endinterface

// File: rtl/ones_vector_gen_mask.sv
// ones_chunk_mask: combinational mask for one CHUNK-bit slice of the vector.
//   idx_i    : chunk index being resolved
//   count_i  : captured (saturated) number of ones
//   offset_i : captured start position, already < WIDTH (ROTATE_EN only)
//   mask_o   : bit j = 1 when position idx*CHUNK+j lies inside the run of ones
// Positions >= WIDTH always resolve to 0.
// Optional macro: ONES_VECTOR_GEN_ROTATE_EN.
module ones_chunk_mask
  import ones_vector_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic [CNT_W-1:0] count_i,
`ifdef ONES_VECTOR_GEN_ROTATE_EN
  input  logic [CNT_W-1:0] offset_i,
`endif
  output logic [CHUNK-1:0] mask_o
);

  localparam logic [CNT_W:0] W_EXT = (CNT_W+1)'(WIDTH);

  logic [CNT_W:0] base;
  assign base = chunk_base(idx_i);

  for (genvar j = 0; j < CHUNK; j++) begin : g_lane
    logic [CNT_W:0] k;    // absolute bit position
    logic [CNT_W:0] rel;  // distance from start of the run, mod WIDTH
    assign k = base + (CNT_W+1)'(j);
`ifdef ONES_VECTOR_GEN_ROTATE_EN
    // k and offset are both < WIDTH, so one conditional add folds the wrap.
    assign rel = (k >= {1'b0, offset_i}) ? k - {1'b0, offset_i}
                                         : k + W_EXT - {1'b0, offset_i};
`else
    assign rel = k;
`endif
    assign mask_o[j] = (k < W_EXT) && (rel < {1'b0, count_i});
  end

endmodule

// File: rtl/ones_vector_gen.sv
// ones_vector_gen: builds a WIDTH-bit thermometer vector with exactly count
// ones (bit 0 upward), CHUNK bits per cycle, behind valid/ready handshakes.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active high; aborts any build, clears out
//   bus  : ones_vector_gen_if.slave (in_valid/in_ready/count[/offset],
//          out_valid/out_ready/out)
// FSM IDLE -> BUILD (NCHUNK cycles) -> DONE (hold until out_ready) -> IDLE.
// out_valid rises NCHUNK edges after the accepting edge; out holds the last
// completed vector until the next one finishes.
// Optional macro: ONES_VECTOR_GEN_ROTATE_EN -- run of ones starts at offset
// and wraps from bit WIDTH-1 to bit 0.
module ones_vector_gen
  import ones_vector_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ones_vector_gen_if.slave   bus
);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] vec_q;
  logic [WIDTH-1:0] vec_d;
  logic [WIDTH-1:0] out_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CHUNK-1:0] mask;
  logic [CNT_W-1:0] cnt_sat;

  // Saturate to WIDTH; only reachable when WIDTH < 2^CNT_W-1.
  assign cnt_sat = ({1'b0, bus.count} > (CNT_W+1)'(WIDTH)) ? CNT_W'(WIDTH) : bus.count;

`ifdef ONES_VECTOR_GEN_ROTATE_EN
  logic [CNT_W-1:0] off_q;
  logic [CNT_W-1:0] off_mod;
  // offset < 2^CNT_W <= 2*WIDTH, so a single subtraction reduces mod WIDTH.
  assign off_mod = ({1'b0, bus.offset} >= (CNT_W+1)'(WIDTH)) ? bus.offset - CNT_W'(WIDTH)
                                                             : bus.offset;
`endif

  ones_chunk_mask u_mask (
    .idx_i    (idx_q),
    .count_i  (cnt_q),
`ifdef ONES_VECTOR_GEN_ROTATE_EN
    .offset_i (off_q),
`endif
    .mask_o   (mask)
  );

  // Merge the freshly resolved chunk into the working vector.
  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    localparam logic [IDX_W-1:0] KIDX = IDX_W'(k / CHUNK);
    assign vec_d[k] = (idx_q == KIDX) ? mask[k % CHUNK] : vec_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      vec_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ONES_VECTOR_GEN_ROTATE_EN
      off_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            cnt_q      <= cnt_sat;
`ifdef ONES_VECTOR_GEN_ROTATE_EN
            off_q      <= off_mod;
`endif
            vec_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUILD;
          end
        end
        BUILD: begin
          vec_q <= vec_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == IDX_W'(NCHUNK - 1)) begin
            out_q       <= vec_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;

endmodule

// File: tb/tb_ones_vector_gen.sv
// tb_ones_vector_gen: self-checking bench for ones_vector_gen. Randomized and
// directed requests are compared against a per-bit reference model of the
// "exactly N ones from offset, wrapping" rule plus a popcount loop-back.
// Optional macro: ONES_VECTOR_GEN_ROTATE_EN enables the offset tests.
module tb_ones_vector_gen;
  import ones_vector_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ones_vector_gen_if bus();

  ones_vector_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: bit k set when (k - offset) mod WIDTH < min(count, WIDTH).
  function automatic logic [WIDTH-1:0] model(input int c, input int off);
    logic [WIDTH-1:0] v;
    int n;
    int o;
    v = '0;
    n = (c > WIDTH) ? WIDTH : c;
    o = off % WIDTH;
    for (int k = 0; k < WIDTH; k++) v[k] = (((k - o + WIDTH) % WIDTH) < n);
    return v;
  endfunction

  function automatic int rnd_off();
`ifdef ONES_VECTOR_GEN_ROTATE_EN
    return int'($urandom_range(0, (1 << CNT_W) - 1));
`else
    return 0;
`endif
  endfunction

  task automatic drive(input int c, input int off);
    bus.in_valid = 1'b1;
    bus.count    = CNT_W'(c);
`ifdef ONES_VECTOR_GEN_ROTATE_EN
    bus.offset   = CNT_W'(off);
`else
    if (off != 0) bus.count = CNT_W'(c);
`endif
  endtask

  // Issue one request, return edges from accept to out_valid (-1 on timeout).
  task automatic run_req(input int c, input int off, output int lat);
    lat = -1;
    drive(c, off);
    for (int i = 0; i < 40 && !bus.in_ready; i++) tick;
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    tick;
    bus.in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    checks++;
    if (bus.out !== '0) begin
      errors++; $display("FAIL reset_out: got %h expected 0", bus.out);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_latency;
    int lat;
    run_req(0, 0, lat);
    checks++;
    if (lat !== NCHUNK) begin
      errors++; $display("FAIL latency_count0: got %0d expected %0d", lat, NCHUNK);
    end
    checks++;
    if (bus.out !== model(0, 0)) begin
      errors++; $display("FAIL zeros: got %h expected %h", bus.out, model(0, 0));
    end
    tick;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_patterns;
    int cs[$];
    int lat;
    int off;
    cs = '{7, 255, 16, 17, 0, 1, 15, 254};
    for (int i = 0; i < 8; i++) cs.push_back(int'($urandom_range(0, WIDTH)));
    foreach (cs[i]) begin
      off = (i < 8) ? 0 : rnd_off();
      run_req(cs[i], off, lat);
      checks++;
      if (lat !== NCHUNK) begin
        errors++; $display("FAIL latency c=%0d: got %0d expected %0d", cs[i], lat, NCHUNK);
      end
      checks++;
      if (bus.out !== model(cs[i], off)) begin
        errors++;
        $display("FAIL vector c=%0d off=%0d: got %h expected %h", cs[i], off, bus.out, model(cs[i], off));
      end
      checks++;
      if ($countones(bus.out) !== cs[i]) begin
        errors++; $display("FAIL popcount c=%0d: got %0d expected %0d", cs[i], $countones(bus.out), cs[i]);
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    int c;
    int c2;
    int lat;
    c   = int'($urandom_range(1, WIDTH - 1));
    c2  = (c + 37) % (WIDTH + 1);
    lat = -1;
    bus.out_ready = 1'b0;
    drive(c, 0);
    tick;
    bus.count = CNT_W'(c2);   // in_valid stays high through BUILD/DONE
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== NCHUNK) begin
      errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, NCHUNK);
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out !== model(c, 0)) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d: got v=%b r=%b out=%h expected 1/0 %h",
                 i, bus.out_valid, bus.in_ready, bus.out, model(c, 0));
      end
    end
    bus.out_ready = 1'b1;
    tick;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out !== model(c, 0)) begin
      errors++;
      $display("FAIL bp_leave: got r=%b v=%b out=%h expected 1/0 %h",
               bus.in_ready, bus.out_valid, bus.out, model(c, 0));
    end
    tick;   // c2 accepted here, first chance after the handshake
    bus.in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== NCHUNK || bus.out !== model(c2, 0)) begin
      errors++;
      $display("FAIL bp_next: got lat=%0d out=%h expected %0d %h", lat, bus.out, NCHUNK, model(c2, 0));
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int t[$];
    int cur;
    int off;
    bus.out_ready = 1'b1;
    cur = int'($urandom_range(0, WIDTH));
    off = rnd_off();
    drive(cur, off);
    for (int cyc = 0; cyc < 100; cyc++) begin
      tick;
      if (bus.out_valid) begin
        checks++;
        if (bus.out !== model(cur, off)) begin
          errors++;
          $display("FAIL b2b_vector c=%0d off=%0d: got %h expected %h", cur, off, bus.out, model(cur, off));
        end
        t.push_back(cyc);
        if (t.size() == 3) begin
          bus.in_valid = 1'b0;
          break;
        end
        cur = int'($urandom_range(0, WIDTH));
        off = rnd_off();
        drive(cur, off);
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (t.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d vectors expected 3", t.size());
    end else begin
      checks++;
      if (t[1] - t[0] != NCHUNK + 2 || t[2] - t[1] != NCHUNK + 2) begin
        errors++;
        $display("FAIL b2b_period: got %0d,%0d expected %0d", t[1] - t[0], t[2] - t[1], NCHUNK + 2);
      end
    end
    tick;
  endtask

  task automatic test_mid_reset;
    int lat;
    logic [WIDTH-1:0] seven;
    seven = WIDTH'(7);
    // Make sure out holds a non-zero vector before the abort.
    run_req(200, 0, lat);
    tick;
    drive(120, 0);
    tick;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick;   // idx now 5
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (bus.out !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_build: got out=%h v=%b r=%b expected 0/0/1", bus.out, bus.out_valid, bus.in_ready);
    end
    run_req(3, 0, lat);
    checks++;
    if (lat !== NCHUNK || bus.out !== seven) begin
      errors++; $display("FAIL after_rst: got lat=%0d out=%h expected %0d %h", lat, bus.out, NCHUNK, seven);
    end
    tick;
    bus.out_ready = 1'b0;
    run_req(100, 0, lat);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.out !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_done: got out=%h v=%b r=%b expected 0/0/1", bus.out, bus.out_valid, bus.in_ready);
    end
  endtask

`ifdef ONES_VECTOR_GEN_ROTATE_EN
  task automatic test_rotate;
    int lat;
    logic [WIDTH-1:0] exp;
    exp = '0;
    exp[253] = 1'b1; exp[254] = 1'b1; exp[0] = 1'b1; exp[1] = 1'b1;
    run_req(4, 253, lat);
    checks++;
    if (lat !== NCHUNK || bus.out !== exp) begin
      errors++; $display("FAIL rot_wrap: got lat=%0d out=%h expected %0d %h", lat, bus.out, NCHUNK, exp);
    end
    checks++;
    if ($countones(bus.out) !== 4) begin
      errors++; $display("FAIL rot_popcount: got %0d expected 4", $countones(bus.out));
    end
    tick;
    run_req(255, 255, lat);
    checks++;
    if (bus.out !== {WIDTH{1'b1}}) begin
      errors++; $display("FAIL rot_full: got %h expected all ones", bus.out);
    end
    tick;
    run_req(10, 250, lat);
    checks++;
    if (bus.out !== model(10, 250)) begin
      errors++; $display("FAIL rot_10_250: got %h expected %h", bus.out, model(10, 250));
    end
    tick;
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.count     = '0;
    bus.out_ready = 1'b1;
`ifdef ONES_VECTOR_GEN_ROTATE_EN
    bus.offset    = '0;
`endif
    test_reset;
    test_latency;
    test_patterns;
    test_backpressure;
    test_back_to_back;
    test_mid_reset;
`ifdef ONES_VECTOR_GEN_ROTATE_EN
    test_rotate;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
